mcu0_intc: RTL and testbench

- Priority interrupt controller that drives the interrupt/irq inputs of the mcu0 CPU core.
- Collects up to 8 device request lines and latches them as pending.
- Presents the highest-priority enabled request to the CPU.
- Tracks the in-service channel until the CPU signals return-from-interrupt (IRET).
- Sits between peripherals and the CPU's interrupt port; a small register port gives software mask and pending control.

---
 rtl/mcu0_intc_pkg.sv | 18 +
 rtl/mcu0_intc_prio.sv | 19 +
 rtl/mcu0_intc.sv | 107 ++++++++++
 tb/tb_mcu0_intc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu0_intc_pkg.sv
// mcu0_intc_pkg: shared state encoding, register map and defaults for the mcu0 interrupt controller.
package mcu0_intc_pkg;

    localparam int NIRQ_DEF = 8;
    localparam int IDW_DEF  = 3;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_INSV = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/mcu0_intc_prio.sv
// mcu0_intc_prio: lowest-index priority encoder over channels 1..NIRQ-1 (channel 0 never requests).
module mcu0_intc_prio #(
    parameter int NIRQ = 8,
    parameter int IDW  = 3
) (
    input  logic [NIRQ-1:1] req,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    always_comb begin
        id = '0;
        for (int i = NIRQ - 1; i > 0; i--)
            if (req[i]) id = IDW'(i);
    end

    assign valid = |req;

endmodule

// File: rtl/mcu0_intc.sv
// mcu0_intc: priority interrupt controller feeding the mcu0 interrupt/irq inputs.
// Define MCU0_INTC_LEVEL_EN for level-sensitive requests; default is rising-edge latched.
module mcu0_intc
    import mcu0_intc_pkg::*;
#(
    parameter int NIRQ = NIRQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NIRQ-1:0] irq_req,
    input  logic            int_ack,
    input  logic            eoi,
    input  logic            wr_en,
    input  logic [1:0]      addr,
    input  logic [7:0]      wr_data,
    output logic [7:0]      rd_data,
    output logic            interrupt,
    output logic [IDW-1:0]  irq
);

    state_t          state, state_nx;
    logic [IDW-1:0]  irq_nx, win_id;
    logic [NIRQ-1:0] mask, pend_q, pending, inservice, cand, sw_set, w1c, ack_clr, hit;
    logic            win_vld, spurious, ack_ok;

    assign hit     = NIRQ'(1) << irq;
    assign ack_ok  = int_ack && state == REQ;
    assign ack_clr = ack_ok ? hit : '0;
    assign sw_set  = (wr_en && addr == REG_STAT) ? {wr_data[NIRQ-1:1], 1'b0} : '0;
    assign w1c     = (wr_en && addr == REG_PEND) ? wr_data[NIRQ-1:0] : '0;

`ifdef MCU0_INTC_LEVEL_EN
    // pend_q only holds software triggers; the live request lines are ORed in.
    assign pending = irq_req | pend_q;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) pend_q <= '0;
        else pend_q <= (pend_q & ~(w1c | ack_clr)) | sw_set;
`else
    logic [NIRQ-1:0] req_q;

    assign pending = pend_q;

    // Set terms are ORed last so a new edge or trigger beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            req_q  <= irq_req;
            pend_q <= (pend_q & ~(w1c | ack_clr)) | sw_set | (irq_req & ~req_q);
        end
`endif

    assign cand = pending & mask;

    mcu0_intc_prio #(.NIRQ(NIRQ), .IDW(IDW)) u_prio (
        .req   (cand[NIRQ-1:1]),
        .valid (win_vld),
        .id    (win_id)
    );

    always_comb begin
        state_nx = state;
        irq_nx   = irq;
        case (state)
            IDLE:    if (win_vld) begin
                state_nx = REQ;
                irq_nx   = win_id;
            end
            REQ:     state_nx = int_ack ? SERVICE : cand[irq] ? REQ : IDLE;
            SERVICE: if (eoi) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            irq   <= '0;
        end else begin
            state <= state_nx;
            irq   <= irq_nx;
        end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            mask      <= '0;
            inservice <= '0;
            spurious  <= 1'b0;
        end else begin
            if (wr_en && addr == REG_MASK) mask <= {wr_data[NIRQ-1:1], 1'b0};
            if (ack_ok) inservice <= hit;
            else if (eoi && state == SERVICE) inservice <= '0;
            if (int_ack && state != REQ) spurious <= 1'b1;
            else if (wr_en && addr == REG_STAT && wr_data[0]) spurious <= 1'b0;
        end

    assign interrupt = state == REQ;

    assign rd_data = addr == REG_MASK ? 8'(mask) :
                     addr == REG_PEND ? 8'(pending) :
                     addr == REG_INSV ? 8'(inservice) :
                     {spurious, 1'b0, state, 1'b0, 3'(irq)};

endmodule

// File: tb/tb_mcu0_intc.sv
// tb_mcu0_intc: scenario tasks push expected values into a queue and pop them as the DUT responds.
module tb_mcu0_intc;
    import mcu0_intc_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq_req = '0;
    logic       int_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       interrupt;
    logic [2:0] irq;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got, e;

    always #5 clock = ~clock;

    mcu0_intc dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .irq_req   (irq_req),
        .int_ack   (int_ack),
        .eoi       (eoi),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .interrupt (interrupt),
        .irq       (irq)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        wr_data = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [7:0] v);
        addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic test_reset();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        tick();
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_intr_irq got=%h exp=%h", got, e); end
        reg_rd(REG_MASK, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_mask got=%h exp=%h", got, e); end
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_pend got=%h exp=%h", got, e); end
        reg_rd(REG_INSV, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_insv got=%h exp=%h", got, e); end
        reg_rd(REG_STAT, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_stat got=%h exp=%h", got, e); end
        reset_n = 1'b1;
        tick();
    endtask

`ifdef MCU0_INTC_LEVEL_EN
    task automatic test_level();
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h09);
        reg_wr(REG_MASK, 8'h02);
        irq_req = 8'h02;
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL level_req got=%h exp=%h", got, e); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL level_ack got=%h exp=%h", got, e); end
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL level_pend_held got=%h exp=%h", got, e); end
        reg_rd(REG_INSV, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL level_insv got=%h exp=%h", got, e); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL level_eoi got=%h exp=%h", got, e); end
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL level_rearm got=%h exp=%h", got, e); end
        irq_req = 8'h00;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask
`else
    task automatic test_basic();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h02);
        reg_wr(REG_MASK, 8'h04);
        irq_req = 8'h04;
        tick();
        irq_req = 8'h00;
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL basic_first_edge got=%h exp=%h", got, e); end
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL basic_req got=%h exp=%h", got, e); end
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL basic_pend got=%h exp=%h", got, e); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL basic_ack got=%h exp=%h", got, e); end
        reg_rd(REG_INSV, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL basic_insv got=%h exp=%h", got, e); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        reg_rd(REG_STAT, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL basic_idle_stat got=%h exp=%h", got, e); end
    endtask

    task automatic test_priority();
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h0D);
        reg_wr(REG_MASK, 8'hFE);
        irq_req = 8'h28;
        tick();
        irq_req = 8'h00;
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL prio_first got=%h exp=%h", got, e); end
        int_ack = 1'b1; eoi = 1'b1; tick(); int_ack = 1'b0; eoi = 1'b0;
        reg_rd(REG_STAT, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL back_to_back_ack_eoi got=%h exp=%h", got, e); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL prio_after_eoi got=%h exp=%h", got, e); end
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL prio_second got=%h exp=%h", got, e); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_mask_drop();
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h00);
        reg_wr(REG_MASK, 8'h10);
        irq_req = 8'h10;
        tick();
        irq_req = 8'h00;
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mask_req got=%h exp=%h", got, e); end
        reg_wr(REG_MASK, 8'h00);
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mask_hold_same_edge got=%h exp=%h", got, e); end
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mask_drop got=%h exp=%h", got, e); end
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mask_pend_kept got=%h exp=%h", got, e); end
        reg_wr(REG_PEND, 8'h10);
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL w1c_clear got=%h exp=%h", got, e); end
    endtask

    task automatic test_set_wins();
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        irq_req = 8'h08;
        reg_wr(REG_PEND, 8'h08);
        irq_req = 8'h00;
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL set_beats_w1c got=%h exp=%h", got, e); end
        reg_wr(REG_PEND, 8'h08);
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL set_wins_cleanup got=%h exp=%h", got, e); end
    endtask

    task automatic test_spurious();
        exp_q.push_back(8'h84);
        exp_q.push_back(8'h04);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        reg_rd(REG_STAT, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL spurious_set got=%h exp=%h", got, e); end
        reg_wr(REG_STAT, 8'h01);
        reg_rd(REG_STAT, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL spurious_clear got=%h exp=%h", got, e); end
    endtask

    task automatic test_trigger_reset();
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h0E);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        reg_wr(REG_STAT, 8'h40);
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL trig_pend got=%h exp=%h", got, e); end
        reg_wr(REG_MASK, 8'h40);
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL trig_not_yet got=%h exp=%h", got, e); end
        tick();
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL trig_req got=%h exp=%h", got, e); end
        reset_n = 1'b0;
        #1;
        got = {4'b0, interrupt, irq};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL midreq_reset_intr got=%h exp=%h", got, e); end
        reg_rd(REG_MASK, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL midreq_reset_mask got=%h exp=%h", got, e); end
        reg_rd(REG_PEND, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL midreq_reset_pend got=%h exp=%h", got, e); end
        reg_rd(REG_INSV, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL midreq_reset_insv got=%h exp=%h", got, e); end
        reg_rd(REG_STAT, got);
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL midreq_reset_stat got=%h exp=%h", got, e); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifdef MCU0_INTC_LEVEL_EN
        test_level();
`else
        test_basic();
        test_priority();
        test_mask_drop();
        test_set_wins();
        test_spurious();
        test_trigger_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
